pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum consecutive MEM_WAIT cycles before the unit halts.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of each performance counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port stall_req  in  1  load-use stall request from the hazard unit.
REQ-006 SHALL have port flush_req  in  1  taken branch/jump resolved in decode.
REQ-007 SHALL have port mem_req  in  1  the memory stage holds a valid load or store.
REQ-008 SHALL have port mem_ready  in  1  data memory completes the access this cycle.
REQ-009 SHALL have port pc_en  out  1  PC register enable.
REQ-010 SHALL have ports ifid_en and idex_en, exmem_en and memwb_en  out  1 each  pipeline register enables.
REQ-011 SHALL have ports ifid_flush, idex_flush and memwb_flush  out  1 each  load a NOP bubble into the register.
REQ-012 SHALL have port state_o  out  2  current FSM state.
REQ-013 SHALL have port mem_err  out  1  sticky timeout flag.
REQ-014 SHALL have ports stall_cycles and flush_count  out  CNT_WIDTH each  performance counters.

Function
REQ-015 SHALL implement three states: RUN=00, MEM_WAIT=01, HALT=10; outputs are combinational from the state and the inputs.
REQ-016 SHALL apply this priority in RUN: memory wait, then stall, then flush, then normal.
REQ-017 SHALL, in RUN with mem_req=1 and mem_ready=0: drive all enables 0 and memwb_flush 1, and move to MEM_WAIT next cycle.
REQ-018 SHALL, in RUN with stall_req=1 and no memory wait: drive pc_en=0, ifid_en=0, idex_flush=1, other enables 1; flush_req is ignored that cycle.
REQ-019 SHALL, in RUN with flush_req=1 and no stall or memory wait: drive all enables 1 and ifid_flush=1.
REQ-020 SHALL, in RUN with no request: drive all enables 1 and all flush outputs 0.
REQ-021 SHALL, in MEM_WAIT with mem_ready=0: drive all enables 0 and memwb_flush 1, and increment wait_cnt.
REQ-022 SHALL, in MEM_WAIT with mem_ready=1: drive outputs per REQ-018..020 using the current stall_req and flush_req, clear wait_cnt, and return to RUN.
REQ-023 SHALL, when wait_cnt reaches MEM_TIMEOUT-1 with mem_ready still 0: set mem_err and enter HALT.
REQ-024 SHALL, in HALT: drive all enables 0 and all flush outputs 0, ignore all inputs, and leave only by reset.
REQ-025 SHALL make mem_ready coinciding with the timeout cycle win, returning to RUN with no error.
REQ-026 SHALL clear wait_cnt on every RUN entry; wait_cnt is at least clog2(MEM_TIMEOUT) bits wide.

Reset
REQ-027 SHALL, while rst_n=0: state=RUN, wait_cnt=0, mem_err=0, counters=0, all enables 0, all flush outputs 1.
REQ-028 SHALL, on reset assertion mid-MEM_WAIT or in HALT: clear the FSM immediately, independent of clk.

Configuration
REQ-029 SHALL, with PIPELINE_CTRL_PERF_CNT_EN defined: stall_cycles counts each cycle pc_en=0 outside reset; flush_count counts each cycle ifid_flush=1; both saturate at all-ones.
REQ-030 SHALL, without PIPELINE_CTRL_PERF_CNT_EN: keep both counter ports present and tied to 0, with no counter flops.

Structure
REQ-031 SHALL place the state enum type and its encodings in package pipeline_ctrl_pkg.
REQ-032 SHALL implement the counters as sub-module sat_counter (parameter WIDTH; inputs clk, rst_n, inc; output count), instantiated twice under the macro.

Verification
REQ-033 SHALL cover: reset release with no requests -> all enables 1, flush outputs 0, state_o=00.
REQ-034 SHALL cover: stall_req=1 and flush_req=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
REQ-035 SHALL cover: mem_req=1 with mem_ready low for 3 cycles then high -> 3 frozen cycles with state_o=01, then all enables 1 and state_o=00.
REQ-036 SHALL cover: MEM_TIMEOUT=4 with mem_ready never asserted -> mem_err=1 and state_o=10 after 4 wait cycles, held until rst_n pulse.
REQ-037 SHALL cover: rst_n dropped mid-MEM_WAIT -> state_o=00 and all enables 0 without a clock edge.
REQ-038 SHALL cover, with the macro defined: 5 stall cycles and 2 flushes -> stall_cycles=5, flush_count=2; with CNT_WIDTH=2, saturation at 3.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared types for the pipeline controller: FSM state encoding, the
//   bundle of pipeline enable/flush controls, and helpers to build them.
//   Imported by pipeline_ctrl and its interface users.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_HALT     = 2'b10
   } state_e;

   // Bit order matters: the constants below are written against it.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_NORMAL = 8'b11111_000;
   // Whole pipe frozen; the bubble keeps a half-finished access out of WB.
   localparam ctrl_t CTRL_FREEZE = 8'b00000_001;
   localparam ctrl_t CTRL_HALT   = 8'b00000_000;
   localparam ctrl_t CTRL_RESET  = 8'b00000_111;

   // Controls for a cycle in which memory is not holding the pipe:
   // a load-use stall beats a branch flush (the flush is simply dropped,
   // the branch gets re-resolved once the stalled instruction moves on).
   function automatic ctrl_t issue_ctrl(input logic stall, input logic flush);
      ctrl_t c;
      c = CTRL_NORMAL;
      if (stall) begin
         c.pc_en      = 1'b0;
         c.ifid_en    = 1'b0;
         c.idex_flush = 1'b1;
      end else if (flush) begin
         c.ifid_flush = 1'b1;
      end
      return c;
   endfunction

   // Wait counter must hold values up to timeout-1; never narrower than 1 bit.
   function automatic int wait_cnt_width(input int timeout);
      return (timeout <= 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
//   Bundles the hazard/memory request inputs and the pipeline control
//   outputs of pipeline_ctrl.
//   Handshake: mem_req marks a load/store sitting in the memory stage;
//   the access completes in any cycle where mem_req (or an outstanding
//   wait) coincides with mem_ready=1. mem_ready may rise without mem_req
//   and is then ignored in RUN.
//   modport master : hazard unit / data memory side (drives requests)
//   modport slave  : pipeline_ctrl (drives enables, flushes, status)
//   Parameter CNT_WIDTH must match the controller's CNT_WIDTH.
interface pipeline_ctrl_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 stall_req;
   logic                 flush_req;
   logic                 mem_req;
   logic                 mem_ready;
   logic                 pc_en;
   logic                 ifid_en;
   logic                 idex_en;
   logic                 exmem_en;
   logic                 memwb_en;
   logic                 ifid_flush;
   logic                 idex_flush;
   logic                 memwb_flush;
   logic [1:0]           state_o;
   logic                 mem_err;
   logic [CNT_WIDTH-1:0] stall_cycles;
   logic [CNT_WIDTH-1:0] flush_count;

   modport master (
      output stall_req, flush_req, mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      input  ifid_flush, idex_flush, memwb_flush,
      input  state_o, mem_err, stall_cycles, flush_count
   );

   modport slave (
      input  stall_req, flush_req, mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      output ifid_flush, idex_flush, memwb_flush,
      output state_o, mem_err, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports: clk, rst_n (async, active-low), inc (count this cycle),
//          count (current value).
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central stall/flush controller for a 5-stage pipeline. Three states:
//   RUN (normal issue), MEM_WAIT (data memory slow, pipe frozen) and
//   HALT (memory never answered; only reset leaves it). All control
//   outputs are combinational from state and current inputs.
//   Ports: clk, rst_n (async, active-low), bus (pipeline_ctrl_if.slave).
//   Parameters: MEM_TIMEOUT (max consecutive MEM_WAIT cycles),
//               CNT_WIDTH (performance counter width).
//   Macro PIPELINE_CTRL_PERF_CNT_EN: when defined, stall_cycles and
//   flush_count are live saturating counters; otherwise tied to zero.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   pipeline_ctrl_if.slave bus
);
   localparam int             WCW       = wait_cnt_width(MEM_TIMEOUT);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

   state_e         state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           mem_err_q, mem_err_d;
   ctrl_t          ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      ctrl       = CTRL_HALT;
      unique case (state_q)
         ST_RUN: begin
            wait_cnt_d = '0;
            if (bus.mem_req && !bus.mem_ready) begin
               ctrl    = CTRL_FREEZE;
               state_d = ST_MEM_WAIT;
            end else begin
               ctrl = issue_ctrl(bus.stall_req, bus.flush_req);
            end
         end
         ST_MEM_WAIT: begin
            // A ready arriving on the timeout cycle still completes cleanly.
            if (bus.mem_ready) begin
               ctrl       = issue_ctrl(bus.stall_req, bus.flush_req);
               wait_cnt_d = '0;
               state_d    = ST_RUN;
            end else begin
               ctrl = CTRL_FREEZE;
               if (wait_cnt_q == WAIT_LAST) begin
                  mem_err_d = 1'b1;
                  state_d   = ST_HALT;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
         end
         ST_HALT: begin
            ctrl = CTRL_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      // Reset overrides combinationally so the pipe is held with bubbles
      // even before the first clock edge.
      if (!rst_n) ctrl = CTRL_RESET;
   end

   assign bus.pc_en       = ctrl.pc_en;
   assign bus.ifid_en     = ctrl.ifid_en;
   assign bus.idex_en     = ctrl.idex_en;
   assign bus.exmem_en    = ctrl.exmem_en;
   assign bus.memwb_en    = ctrl.memwb_en;
   assign bus.ifid_flush  = ctrl.ifid_flush;
   assign bus.idex_flush  = ctrl.idex_flush;
   assign bus.memwb_flush = ctrl.memwb_flush;
   assign bus.state_o     = state_q;
   assign bus.mem_err     = mem_err_q;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
   // Counters sit in reset alongside the FSM, so reset cycles never count.
   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~ctrl.pc_en),
      .count (bus.stall_cycles)
   );
   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ctrl.ifid_flush),
      .count (bus.flush_count)
   );
`else
   assign bus.stall_cycles = '0;
   assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed vector table, hand-written multi-cycle sequences and a
//   randomized run, all compared against a behavioural model of the
//   controller kept in this file.
module tb_pipeline_ctrl;
   localparam int TMO  = 4;
   localparam int CW   = 8;
   localparam longint CMAX = (64'd1 << CW) - 1;

   // Control vector order: {pc,ifid,idex,exmem,memwb, ifid_f,idex_f,memwb_f}
   localparam logic [7:0] C_NORM   = 8'b11111_000;
   localparam logic [7:0] C_STALL  = 8'b00111_010;
   localparam logic [7:0] C_FLUSH  = 8'b11111_100;
   localparam logic [7:0] C_FREEZE = 8'b00000_001;
   localparam logic [7:0] C_HALT   = 8'b00000_000;
   localparam logic [7:0] C_RESET  = 8'b00000_111;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipeline_ctrl_if #(.CNT_WIDTH(CW)) bus ();

   pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic       sc_inc = 1'b0;
   logic [1:0] sc_count;
   sat_counter #(.WIDTH(2)) u_sc (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sc_inc),
      .count (sc_count)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks "is a memory access outstanding", how many wait cycles have
   // fully elapsed, and whether the unit gave up.
   bit     m_wait, m_halt, m_err;
   int     m_waits;
   longint m_stall, m_flush;

   function automatic void model_reset();
      m_wait = 0; m_halt = 0; m_err = 0; m_waits = 0;
      m_stall = 0; m_flush = 0;
   endfunction

   function automatic logic [7:0] model_ctrl(input logic s, f, m, r);
      if (m_halt) return C_HALT;
      if (!r && (m_wait || m)) return C_FREEZE;
      if (s) return C_STALL;
      if (f) return C_FLUSH;
      return C_NORM;
   endfunction

   function automatic logic [1:0] model_state();
      return m_halt ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
   endfunction

   function automatic longint exp_cnt(input longint v);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
      return v;
`else
      return 0;
`endif
   endfunction

   function automatic void model_step(input logic s, f, m, r);
      logic [7:0] c;
      c = model_ctrl(s, f, m, r);
      if (!c[7] && m_stall < CMAX) m_stall++;
      if (c[2] && m_flush < CMAX) m_flush++;
      if (m_halt) return;
      if (!r && (m_wait || m)) begin
         if (m_wait) begin
            m_waits++;
            if (m_waits >= TMO) begin
               m_halt = 1; m_err = 1; m_wait = 0;
            end
         end else begin
            m_wait = 1; m_waits = 0;
         end
      end else begin
         m_wait = 0; m_waits = 0;
      end
   endfunction

   // ---------------- driver tasks ----------------
   function automatic logic [7:0] act_ctrl();
      return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
              bus.ifid_flush, bus.idex_flush, bus.memwb_flush};
   endfunction

   // Called at posedge+1; drives inputs, checks at negedge, advances model.
   task automatic cycle(input logic s, f, m, r,
                        output logic [7:0] a_ctrl, output logic [1:0] a_st);
      bus.stall_req = s; bus.flush_req = f; bus.mem_req = m; bus.mem_ready = r;
      @(negedge clk);
      a_ctrl = act_ctrl();
      a_st   = bus.state_o;
      chk("ctrl",         a_ctrl, model_ctrl(s, f, m, r));
      chk("state",        a_st, model_state());
      chk("mem_err",      bus.mem_err, m_err);
      chk("stall_cycles", bus.stall_cycles, exp_cnt(m_stall));
      chk("flush_count",  bus.flush_count, exp_cnt(m_flush));
      @(posedge clk);
      model_step(s, f, m, r);
      #1;
   endtask

   // Drops reset between clock edges and checks the outputs right away.
   task automatic do_reset(input string name);
      rst_n = 1'b0;
      #1;
      chk({name, "_ctrl"},  act_ctrl(), C_RESET);
      chk({name, "_state"}, bus.state_o, 2'd0);
      chk({name, "_err"},   bus.mem_err, 1'b0);
      chk({name, "_scnt"},  bus.stall_cycles, 0);
      chk({name, "_fcnt"},  bus.flush_count, 0);
      model_reset();
      bus.stall_req = 0; bus.flush_req = 0; bus.mem_req = 0; bus.mem_ready = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic       s, f, m, r;
      logic [7:0] ctrl;
      logic [1:0] st;
   } vec_t;

   vec_t       tbl[9];
   logic [7:0] a_c;
   logic [1:0] a_s;
   int         ready_pct;

   initial begin
      tbl[0] = '{0, 0, 0, 0, C_NORM,   2'd0};
      tbl[1] = '{1, 1, 0, 0, C_STALL,  2'd0};
      tbl[2] = '{0, 1, 0, 0, C_FLUSH,  2'd0};
      tbl[3] = '{0, 0, 1, 1, C_NORM,   2'd0};
      tbl[4] = '{1, 0, 1, 1, C_STALL,  2'd0};
      tbl[5] = '{0, 0, 1, 0, C_FREEZE, 2'd0};
      tbl[6] = '{0, 0, 0, 0, C_FREEZE, 2'd1};
      tbl[7] = '{1, 1, 0, 1, C_STALL,  2'd1};
      tbl[8] = '{0, 0, 0, 0, C_NORM,   2'd0};

      bus.stall_req = 0; bus.flush_req = 0; bus.mem_req = 0; bus.mem_ready = 0;
      model_reset();

      // Reset held from time 0.
      #2;
      chk("por_ctrl",  act_ctrl(), C_RESET);
      chk("por_state", bus.state_o, 2'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset release, no requests.
      cycle(0, 0, 0, 0, a_c, a_s);
      chk("release_ctrl",  a_c, C_NORM);
      chk("release_state", a_s, 2'd0);

      // Saturating counter sub-module at WIDTH=2 (inputs idle, DUT stays put).
      sc_inc = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("sat2_mid", sc_count, 2'd2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sat2_top", sc_count, 2'd3);
      sc_inc = 1'b0;
      @(posedge clk); #1;

      // Directed vector table.
      foreach (tbl[i]) begin
         cycle(tbl[i].s, tbl[i].f, tbl[i].m, tbl[i].r, a_c, a_s);
         chk($sformatf("vec%0d_ctrl", i), a_c, tbl[i].ctrl);
         chk($sformatf("vec%0d_state", i), a_s, tbl[i].st);
      end

      // Long memory wait that completes before the timeout.
      do_reset("rst_a");
      cycle(0, 0, 1, 0, a_c, a_s);
      chk("mw_enter", a_c, C_FREEZE);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 0, a_c, a_s);
         chk("mw_frozen_ctrl",  a_c, C_FREEZE);
         chk("mw_frozen_state", a_s, 2'd1);
      end
      cycle(0, 0, 0, 1, a_c, a_s);
      chk("mw_done_ctrl",  a_c, C_NORM);
      chk("mw_done_state", a_s, 2'd1);
      cycle(0, 0, 0, 0, a_c, a_s);
      chk("mw_back_state", a_s, 2'd0);

      // Ready arriving on the last allowed wait cycle.
      cycle(0, 0, 1, 0, a_c, a_s);
      for (int i = 0; i < TMO - 1; i++) cycle(0, 0, 0, 0, a_c, a_s);
      cycle(0, 1, 0, 1, a_c, a_s);
      chk("edge_ready_ctrl", a_c, C_FLUSH);
      cycle(0, 0, 0, 0, a_c, a_s);
      chk("edge_ready_state", a_s, 2'd0);
      chk("edge_ready_err",   bus.mem_err, 1'b0);

      // Timeout into HALT, held regardless of inputs.
      cycle(0, 0, 1, 0, a_c, a_s);
      for (int i = 0; i < TMO; i++) cycle(0, 0, 0, 0, a_c, a_s);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 1, 1, a_c, a_s);
         chk("halt_ctrl",  a_c, C_HALT);
         chk("halt_state", a_s, 2'd2);
         chk("halt_err",   bus.mem_err, 1'b1);
      end
      do_reset("rst_halt");

      // Reset dropped mid-wait acts without a clock edge.
      cycle(0, 0, 1, 0, a_c, a_s);
      cycle(0, 0, 1, 0, a_c, a_s);
      do_reset("rst_midwait");

      // Performance counters: 5 stall cycles, 2 flushes.
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, a_c, a_s);
      for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, a_c, a_s);
      cycle(0, 0, 0, 0, a_c, a_s);
      chk("perf_stall", bus.stall_cycles, exp_cnt(5));
      chk("perf_flush", bus.flush_count, exp_cnt(2));

      // Randomized run against the model.
      for (int blk = 0; blk < 4; blk++) begin
         ready_pct = (blk % 2 == 0) ? 75 : 35;
         for (int i = 0; i < 120; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 99) < ready_pct,
                  a_c, a_s);
            if (m_halt && $urandom_range(0, 3) == 0) do_reset("rst_rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
